// File: rtl/tex_addr_pipe.sv
// Two-stage texture address pipeline: S1 flips/windows texel coords, S2 forms halfword address.
// Define TEX_ADDR_WINDOW_EN to apply the texture window mask/offset in S1.
module tex_addr_pipe #(
  parameter int unsigned LANES = 2
) (
  input  logic                 clk,
  input  logic                 i_rst,
  input  logic [3:0]           GPU_REG_TexBasePageX,
  input  logic                 GPU_REG_TexBasePageY,
  input  logic                 GPU_REG_TextureXFlip,
  input  logic                 GPU_REG_TextureYFlip,
  input  logic [1:0]           GPU_REG_TexFormat,
  input  logic [4:0]           GPU_REG_WindowTextureMaskX,
  input  logic [4:0]           GPU_REG_WindowTextureMaskY,
  input  logic [4:0]           GPU_REG_WindowTextureOffsetX,
  input  logic [4:0]           GPU_REG_WindowTextureOffsetY,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [8*LANES-1:0]   i_coordU,
  input  logic [8*LANES-1:0]   i_coordV,
  input  logic [LANES-1:0]     i_laneMask,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [19*LANES-1:0]  o_texelAddr,
  output logic [2*LANES-1:0]   o_subSel,
  output logic [LANES-1:0]     o_laneMask,
  output logic [LANES-1:0]     o_sameWord
);
  localparam int unsigned CW = 8;
  localparam int unsigned OW = 10;
  localparam int unsigned AW = 19;

  logic                        s1_valid_q, s1_valid_d;
  logic [LANES-1:0][CW-1:0]    s1_u_q, s1_u_d, s1_v_q, s1_v_d;
  logic [LANES-1:0]            s1_mask_q, s1_mask_d;
  logic [3:0]                  s1_pagex_q, s1_pagex_d;
  logic                        s1_pagey_q, s1_pagey_d;
  logic [1:0]                  s1_fmt_q, s1_fmt_d;

  logic                        s2_valid_q, s2_valid_d;
  logic [LANES-1:0][AW-1:0]    s2_addr_q, s2_addr_d;
  logic [LANES-1:0][1:0]       s2_sub_q, s2_sub_d;
  logic [LANES-1:0]            s2_mask_q, s2_mask_d;
  logic [LANES-1:0]            s2_same_q, s2_same_d;

  logic [LANES-1:0][CW-1:0]    xf_u, xf_v;
  logic [LANES-1:0][OW-1:0]    lane_off;
  logic [LANES-1:0][AW-1:0]    lane_addr;
  logic [LANES-1:0][1:0]       lane_sub;
  logic [LANES-1:0]            lane_same;
  logic                        s1_load, s2_load;

  // S2 accepts when empty or draining; S1 accepts when empty or advancing into S2.
  assign s2_load = !s2_valid_q || i_ready;
  assign s1_load = !s1_valid_q || s2_load;
  assign o_ready = !i_rst && s1_load;

  // Coordinate transform applied to the incoming request.
  always_comb begin
    xf_u = '0;
    xf_v = '0;
    for (int k = 0; k < LANES; k++) begin
      xf_u[k] = GPU_REG_TextureXFlip ? ~i_coordU[CW*k +: CW] : i_coordU[CW*k +: CW];
      xf_v[k] = GPU_REG_TextureYFlip ? ~i_coordV[CW*k +: CW] : i_coordV[CW*k +: CW];
`ifdef TEX_ADDR_WINDOW_EN
      xf_u[k] = (xf_u[k] & ~{GPU_REG_WindowTextureMaskX, 3'b000})
              | {GPU_REG_WindowTextureOffsetX & GPU_REG_WindowTextureMaskX, 3'b000};
      xf_v[k] = (xf_v[k] & ~{GPU_REG_WindowTextureMaskY, 3'b000})
              | {GPU_REG_WindowTextureOffsetY & GPU_REG_WindowTextureMaskY, 3'b000};
`endif
    end
  end

`ifndef TEX_ADDR_WINDOW_EN
  logic unused_win;
  assign unused_win = ^{GPU_REG_WindowTextureMaskX, GPU_REG_WindowTextureMaskY,
                        GPU_REG_WindowTextureOffsetX, GPU_REG_WindowTextureOffsetY};
`endif

  // Halfword address from S1 contents; format 3 shares the 16-bit path.
  always_comb begin
    lane_off  = '0;
    lane_addr = '0;
    lane_sub  = '0;
    lane_same = '0;
    for (int k = 0; k < LANES; k++) begin
      case (s1_fmt_q)
        2'd0: begin
          lane_off[k] = OW'(s1_u_q[k] >> 2);
          lane_sub[k] = s1_u_q[k][1:0];
        end
        2'd1: begin
          lane_off[k] = OW'(s1_u_q[k] >> 1);
          lane_sub[k] = {1'b0, s1_u_q[k][0]};
        end
        default: begin
          lane_off[k] = OW'(s1_u_q[k]);
          lane_sub[k] = 2'b00;
        end
      endcase
      lane_addr[k] = {s1_pagey_q, s1_v_q[k], OW'({s1_pagex_q, 6'b000000} + lane_off[k])};
    end
    for (int k = 0; k < LANES; k++) begin
      lane_same[k] = s1_mask_q[k] & s1_mask_q[0] & (lane_addr[k] == lane_addr[0]);
    end
  end

  // Next-state for both pipeline stages.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_u_d     = s1_u_q;
    s1_v_d     = s1_v_q;
    s1_mask_d  = s1_mask_q;
    s1_pagex_d = s1_pagex_q;
    s1_pagey_d = s1_pagey_q;
    s1_fmt_d   = s1_fmt_q;
    s2_valid_d = s2_valid_q;
    s2_addr_d  = s2_addr_q;
    s2_sub_d   = s2_sub_q;
    s2_mask_d  = s2_mask_q;
    s2_same_d  = s2_same_q;
    if (s1_load) begin
      s1_valid_d = i_valid;
      if (i_valid) begin
        s1_u_d     = xf_u;
        s1_v_d     = xf_v;
        s1_mask_d  = i_laneMask;
        s1_pagex_d = GPU_REG_TexBasePageX;
        s1_pagey_d = GPU_REG_TexBasePageY;
        s1_fmt_d   = GPU_REG_TexFormat;
      end
    end
    if (s2_load) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_addr_d = lane_addr;
        s2_sub_d  = lane_sub;
        s2_mask_d = s1_mask_q;
        s2_same_d = lane_same;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      s1_valid_q <= 1'b0;
      s1_u_q     <= '0;
      s1_v_q     <= '0;
      s1_mask_q  <= '0;
      s1_pagex_q <= '0;
      s1_pagey_q <= 1'b0;
      s1_fmt_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_addr_q  <= '0;
      s2_sub_q   <= '0;
      s2_mask_q  <= '0;
      s2_same_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_u_q     <= s1_u_d;
      s1_v_q     <= s1_v_d;
      s1_mask_q  <= s1_mask_d;
      s1_pagex_q <= s1_pagex_d;
      s1_pagey_q <= s1_pagey_d;
      s1_fmt_q   <= s1_fmt_d;
      s2_valid_q <= s2_valid_d;
      s2_addr_q  <= s2_addr_d;
      s2_sub_q   <= s2_sub_d;
      s2_mask_q  <= s2_mask_d;
      s2_same_q  <= s2_same_d;
    end
  end

  assign o_valid     = s2_valid_q;
  assign o_texelAddr = s2_addr_q;
  assign o_subSel    = s2_sub_q;
  assign o_laneMask  = s2_mask_q;
  assign o_sameWord  = s2_same_q;

endmodule

// File: tb/tb_tex_addr_pipe.sv
// Directed self-checking bench for tex_addr_pipe with LANES=2; window expectations follow TEX_ADDR_WINDOW_EN.
module tb_tex_addr_pipe;
  localparam int unsigned LANES = 2;

  logic        clk;
  logic        i_rst;
  logic [3:0]  pagex;
  logic        pagey;
  logic        xflip, yflip;
  logic [1:0]  fmt;
  logic [4:0]  mask_x, mask_y, off_x, off_y;
  logic        i_valid, o_ready, o_valid, i_ready;
  logic [8*LANES-1:0]  i_coordU, i_coordV;
  logic [LANES-1:0]    i_laneMask, o_laneMask, o_sameWord;
  logic [19*LANES-1:0] o_texelAddr;
  logic [2*LANES-1:0]  o_subSel;

  int n_checks = 0;
  int n_fail   = 0;

  tex_addr_pipe #(.LANES(LANES)) dut (
    .clk                          (clk),
    .i_rst                        (i_rst),
    .GPU_REG_TexBasePageX         (pagex),
    .GPU_REG_TexBasePageY         (pagey),
    .GPU_REG_TextureXFlip         (xflip),
    .GPU_REG_TextureYFlip         (yflip),
    .GPU_REG_TexFormat            (fmt),
    .GPU_REG_WindowTextureMaskX   (mask_x),
    .GPU_REG_WindowTextureMaskY   (mask_y),
    .GPU_REG_WindowTextureOffsetX (off_x),
    .GPU_REG_WindowTextureOffsetY (off_y),
    .i_valid                      (i_valid),
    .o_ready                      (o_ready),
    .i_coordU                     (i_coordU),
    .i_coordV                     (i_coordV),
    .i_laneMask                   (i_laneMask),
    .o_valid                      (o_valid),
    .i_ready                      (i_ready),
    .o_texelAddr                  (o_texelAddr),
    .o_subSel                     (o_subSel),
    .o_laneMask                   (o_laneMask),
    .o_sameWord                   (o_sameWord)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_cfg(input logic [3:0] px, input logic py, input logic xf, input logic yf,
                         input logic [1:0] f, input logic [4:0] mx, input logic [4:0] my,
                         input logic [4:0] ox, input logic [4:0] oy);
    pagex = px; pagey = py; xflip = xf; yflip = yf; fmt = f;
    mask_x = mx; mask_y = my; off_x = ox; off_y = oy;
  endtask

  // One request into an empty pipe with i_ready high; config is scrambled right after acceptance.
  task automatic issue(input logic [15:0] u, input logic [15:0] v, input logic [1:0] m,
                       output logic rdy0, output logic v1, output logic v2,
                       output logic [37:0] a, output logic [3:0] s,
                       output logic [1:0] lm, output logic [1:0] sw);
    i_coordU = u; i_coordV = v; i_laneMask = m; i_valid = 1'b1;
    #1 rdy0 = o_ready;
    @(posedge clk); #1;
    i_valid = 1'b0;
    pagex = ~pagex; pagey = ~pagey; xflip = ~xflip; yflip = ~yflip; fmt = fmt ^ 2'd1;
    mask_x = ~mask_x; mask_y = ~mask_y; off_x = ~off_x; off_y = ~off_y;
    v1 = o_valid;
    @(posedge clk); #1;
    v2 = o_valid; a = o_texelAddr; s = o_subSel; lm = o_laneMask; sw = o_sameWord;
    @(posedge clk); #1;
  endtask

  function automatic logic [37:0] exp_stream(input int j);
    logic [7:0] u0, v0, u1;
    u0 = 8'(j * 16 + 1);
    v0 = 8'(j);
    u1 = 8'(j);
    return {1'b0, 8'h00, 2'b00, u1, 1'b0, v0, 2'b00, u0};
  endfunction

  task automatic test_reset();
    i_rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", o_ready); end
    n_checks++; if ({o_texelAddr, o_subSel, o_laneMask, o_sameWord} !== 46'd0) begin
      n_fail++; $display("FAIL reset_data: got %h expected 0", {o_texelAddr, o_subSel, o_laneMask, o_sameWord}); end
    i_rst = 1'b0;
    #1;
    n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b expected 1", o_ready); end
  endtask

  task automatic test_wrap_fmt2();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    set_cfg(4'd15, 1'b1, 1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0);
    issue({8'h00, 8'hFF}, {8'h20, 8'h10}, 2'b11, r, v1, v2, a, s, lm, sw);
    n_checks++; if ({r, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL wrap_latency: got %b expected 101", {r, v1, v2}); end
    n_checks++; if (a !== {1'b1, 8'h20, 10'd960, 1'b1, 8'h10, 10'd191}) begin
      n_fail++; $display("FAIL wrap_addr: got %h expected %h", a, {1'b1, 8'h20, 10'd960, 1'b1, 8'h10, 10'd191}); end
    n_checks++; if (s !== 4'd0) begin n_fail++; $display("FAIL wrap_sub: got %h expected 0", s); end
    n_checks++; if ({lm, sw} !== 4'b1101) begin n_fail++; $display("FAIL wrap_flags: got %b expected 1101", {lm, sw}); end
  endtask

  task automatic test_flip_fmt0();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    set_cfg(4'd2, 1'b0, 1'b1, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    issue({8'h00, 8'h37}, {8'h05, 8'h05}, 2'b01, r, v1, v2, a, s, lm, sw);
    n_checks++; if ({r, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL flip_latency: got %b expected 101", {r, v1, v2}); end
    n_checks++; if (a !== {1'b0, 8'h05, 10'd191, 1'b0, 8'h05, 10'd178}) begin
      n_fail++; $display("FAIL flip_addr: got %h expected %h", a, {1'b0, 8'h05, 10'd191, 1'b0, 8'h05, 10'd178}); end
    n_checks++; if (s !== {2'd3, 2'd0}) begin n_fail++; $display("FAIL flip_sub: got %h expected c", s); end
    n_checks++; if ({lm, sw} !== 4'b0101) begin n_fail++; $display("FAIL flip_flags: got %b expected 0101", {lm, sw}); end
  endtask

  task automatic test_fmt3_yflip();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    set_cfg(4'd0, 1'b0, 1'b0, 1'b1, 2'd3, 5'd0, 5'd0, 5'd0, 5'd0);
    issue({8'h12, 8'h12}, {8'h0F, 8'h0F}, 2'b11, r, v1, v2, a, s, lm, sw);
    n_checks++; if (a !== {1'b0, 8'hF0, 10'h012, 1'b0, 8'hF0, 10'h012}) begin
      n_fail++; $display("FAIL fmt3_addr: got %h expected %h", a, {1'b0, 8'hF0, 10'h012, 1'b0, 8'hF0, 10'h012}); end
    n_checks++; if (s !== 4'd0) begin n_fail++; $display("FAIL fmt3_sub: got %h expected 0", s); end
    n_checks++; if ({lm, sw} !== 4'b1111) begin n_fail++; $display("FAIL fmt3_flags: got %b expected 1111", {lm, sw}); end
  endtask

  task automatic test_window();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    logic [37:0] exp_a;
`ifdef TEX_ADDR_WINDOW_EN
    exp_a = {1'b0, 8'h10, 10'h029, 1'b0, 8'hF7, 10'h02F};
`else
    exp_a = {1'b0, 8'h00, 10'h001, 1'b0, 8'hFF, 10'h0FF};
`endif
    set_cfg(4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 5'h1F, 5'h03, 5'h05, 5'h06);
    issue({8'h01, 8'hFF}, {8'h00, 8'hFF}, 2'b11, r, v1, v2, a, s, lm, sw);
    n_checks++; if ({r, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL window_latency: got %b expected 101", {r, v1, v2}); end
    n_checks++; if (a !== exp_a) begin n_fail++; $display("FAIL window_addr: got %h expected %h", a, exp_a); end
    n_checks++; if ({lm, sw} !== 4'b1101) begin n_fail++; $display("FAIL window_flags: got %b expected 1101", {lm, sw}); end
  endtask

  task automatic test_fmt1_sameword();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    set_cfg(4'd3, 1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    issue({8'h41, 8'h40}, {8'h22, 8'h22}, 2'b11, r, v1, v2, a, s, lm, sw);
    n_checks++; if (a !== {1'b0, 8'h22, 10'd224, 1'b0, 8'h22, 10'd224}) begin
      n_fail++; $display("FAIL fmt1_addr: got %h expected %h", a, {1'b0, 8'h22, 10'd224, 1'b0, 8'h22, 10'd224}); end
    n_checks++; if (s !== {2'd1, 2'd0}) begin n_fail++; $display("FAIL fmt1_sub: got %h expected 4", s); end
    n_checks++; if ({lm, sw} !== 4'b1111) begin n_fail++; $display("FAIL fmt1_same: got %b expected 1111", {lm, sw}); end
    set_cfg(4'd3, 1'b0, 1'b0, 1'b0, 2'd1, 5'd0, 5'd0, 5'd0, 5'd0);
    issue({8'h41, 8'h40}, {8'h22, 8'h22}, 2'b10, r, v1, v2, a, s, lm, sw);
    n_checks++; if ({lm, sw} !== 4'b1000) begin n_fail++; $display("FAIL lane0_off_same: got %b expected 1000", {lm, sw}); end
    n_checks++; if (a !== {1'b0, 8'h22, 10'd224, 1'b0, 8'h22, 10'd224}) begin
      n_fail++; $display("FAIL lane0_off_addr: got %h expected %h", a, {1'b0, 8'h22, 10'd224, 1'b0, 8'h22, 10'd224}); end
  endtask

  task automatic test_back_to_back();
    int nrecv;
    nrecv = 0;
    set_cfg(4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0);
    i_ready = 1'b1;
    i_laneMask = 2'b11;
    for (int c = 0; c < 8; c++) begin
      i_valid  = (c < 6);
      i_coordU = {8'(c), 8'(c * 16 + 1)};
      i_coordV = {8'h00, 8'(c)};
      #1;
      n_checks++; if (o_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_ready c=%0d: got %b expected 1", c, o_ready); end
      n_checks++; if (o_valid !== (c >= 2)) begin n_fail++; $display("FAIL b2b_valid c=%0d: got %b expected %b", c, o_valid, (c >= 2)); end
      if (o_valid) begin
        n_checks++; if (o_texelAddr !== exp_stream(nrecv)) begin
          n_fail++; $display("FAIL b2b_addr #%0d: got %h expected %h", nrecv, o_texelAddr, exp_stream(nrecv)); end
        nrecv++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    n_checks++; if (nrecv !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d expected 6", nrecv); end
  endtask

  task automatic test_backpressure();
    int nsent, nrecv;
    logic exp_rdy;
    nsent = 0; nrecv = 0;
    set_cfg(4'd0, 1'b0, 1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0);
    i_laneMask = 2'b11;
    for (int c = 0; c < 100 && nrecv < 8; c++) begin
      i_ready  = ((c % 4) == 0) || ((c % 4) == 3);
      i_valid  = (nsent < 8);
      i_coordU = {8'(nsent), 8'(nsent * 16 + 1)};
      i_coordV = {8'h00, 8'(nsent)};
      #1;
      exp_rdy = !((nsent - nrecv) == 2 && !i_ready);
      n_checks++; if (o_ready !== exp_rdy) begin n_fail++; $display("FAIL bp_ready c=%0d: got %b expected %b", c, o_ready, exp_rdy); end
      if (i_valid && o_ready) nsent++;
      if (o_valid && i_ready) begin
        n_checks++; if (o_texelAddr !== exp_stream(nrecv)) begin
          n_fail++; $display("FAIL bp_addr #%0d: got %h expected %h", nrecv, o_texelAddr, exp_stream(nrecv)); end
        nrecv++;
      end
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    n_checks++; if (nrecv !== 8) begin n_fail++; $display("FAIL bp_count: got %0d expected 8", nrecv); end
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL bp_no_extra: got %b expected 0", o_valid); end
  endtask

  task automatic test_reset_midflight();
    logic r, v1, v2; logic [37:0] a; logic [3:0] s; logic [1:0] lm, sw;
    set_cfg(4'd1, 1'b0, 1'b0, 1'b0, 2'd2, 5'd0, 5'd0, 5'd0, 5'd0);
    i_ready = 1'b0;
    i_laneMask = 2'b11;
    i_valid = 1'b1;
    i_coordU = 16'h1111; i_coordV = 16'h2222;
    @(posedge clk); #1;
    i_coordU = 16'h5555; i_coordV = 16'h6666;
    @(posedge clk); #1;
    i_valid = 1'b0;
    n_checks++; if ({o_valid, o_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_full: got %b expected 10", {o_valid, o_ready}); end
    i_rst = 1'b1;
    #1;
    n_checks++; if (o_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b expected 0", o_ready); end
    @(posedge clk); #1;
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid: got %b expected 0", o_valid); end
    n_checks++; if ({o_texelAddr, o_laneMask, o_sameWord} !== 42'd0) begin
      n_fail++; $display("FAIL mid_rst_data: got %h expected 0", {o_texelAddr, o_laneMask, o_sameWord}); end
    i_rst = 1'b0;
    i_ready = 1'b1;
    issue({8'h33, 8'h33}, {8'h44, 8'h44}, 2'b11, r, v1, v2, a, s, lm, sw);
    n_checks++; if ({r, v1, v2} !== 3'b101) begin n_fail++; $display("FAIL post_rst_latency: got %b expected 101", {r, v1, v2}); end
    n_checks++; if (a !== {1'b0, 8'h44, 10'd115, 1'b0, 8'h44, 10'd115}) begin
      n_fail++; $display("FAIL post_rst_addr: got %h expected %h", a, {1'b0, 8'h44, 10'd115, 1'b0, 8'h44, 10'd115}); end
    n_checks++; if ({lm, sw} !== 4'b1111) begin n_fail++; $display("FAIL post_rst_flags: got %b expected 1111", {lm, sw}); end
    n_checks++; if (o_valid !== 1'b0) begin n_fail++; $display("FAIL post_rst_ghost: got %b expected 0", o_valid); end
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    i_coordU = '0;
    i_coordV = '0;
    i_laneMask = '0;
    set_cfg(4'd0, 1'b0, 1'b0, 1'b0, 2'd0, 5'd0, 5'd0, 5'd0, 5'd0);
    test_reset();
    test_wrap_fmt2();
    test_flip_fmt0();
    test_fmt3_yflip();
    test_window();
    test_fmt1_sameword();
    test_back_to_back();
    test_backpressure();
    test_reset_midflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tex_addr_pipe.md
TEX_ADDR_PIPE -- requirements
Module: tex_addr_pipe

Interface
REQ-001 Parameter LANES, default 2, range 1..4: texel lanes processed per request.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 i_rst  input  1  synchronous, active-high reset.
REQ-004 GPU_REG_TexBasePageX  input  4  texture page X base, 64-halfword units.
REQ-005 GPU_REG_TexBasePageY  input  1  texture page Y base, 256-line units.
REQ-006 GPU_REG_TextureXFlip / GPU_REG_TextureYFlip  input  1 each  invert U / V.
REQ-007 GPU_REG_TexFormat  input  2  0=4-bit, 1=8-bit, 2=16-bit, 3=reserved.
REQ-008 GPU_REG_WindowTextureMaskX/MaskY/OffsetX/OffsetY  input  5 each  texture window, 8-texel steps.
REQ-009 i_valid  input  1  request present; i_coordU/i_coordV/i_laneMask stable while i_valid && !o_ready.
REQ-010 o_ready  output  1  request accepted on cycle with i_valid && o_ready.
REQ-011 i_coordU, i_coordV  input  8*LANES each  lane k at bits [8k+7:8k].
REQ-012 i_laneMask  input  LANES  per-lane enable, carried through unchanged.
REQ-013 o_valid  output  1  result present; held with stable data until i_ready.
REQ-014 i_ready  input  1  consumer accepts result when o_valid && i_ready.
REQ-015 o_texelAddr  output  19*LANES  halfword address per lane: {PageY, V[7:0], adr[9:0]}.
REQ-016 o_subSel  output  2*LANES  sub-halfword index per lane.
REQ-017 o_laneMask  output  LANES  delayed i_laneMask.
REQ-018 o_sameWord  output  LANES  bit k=1 when lane k enabled, lane 0 enabled and addresses equal; bit 0 = i_laneMask[0].

Function
REQ-019 Pipeline: two registered stages S1 (coord transform), S2 (address); latency exactly 2 cycles from acceptance to o_valid with no stall.
REQ-020 Config registers sampled at acceptance into S1 with the request; later config changes never alter in-flight requests.
REQ-021 S1 per lane: U' = XFlip ? ~U : U; V' = YFlip ? ~V : V; then U'' = (U' & ~{MaskX,3'b0}) | {OffsetX&MaskX,3'b0}, same for V with Y fields.
REQ-022 S2 adr = {PageX,6'b0} + U''>>2 (fmt 0), U''>>1 (fmt 1), U'' (fmt 2 or 3), sum truncated to 10 bits (wrap modulo 1024).
REQ-023 o_subSel = U''[1:0] (fmt 0), {1'b0,U''[0]} (fmt 1), 2'b00 (fmt 2/3).
REQ-024 Format 3 behaves exactly as 16-bit.
REQ-025 Handshake: S2 loads when S2 empty or i_ready; S1 loads when S1 empty or S1 advancing; o_ready = !i_rst && (S1 empty || S1 advancing).
REQ-026 Full-throughput: with i_valid and i_ready held high, one result per cycle, no bubbles.
REQ-027 Backpressure: i_ready low with both stages full drops o_ready same cycle; no request lost or duplicated.
REQ-028 Simultaneous S2 drain and S1 load in one cycle permitted; order preserved.
REQ-029 Disabled lanes still compute addresses; only o_laneMask/o_sameWord reflect the mask.

Reset
REQ-030 i_rst high: S1/S2 valid cleared next edge; o_valid=0, o_ready=0 while i_rst asserted; data registers, o_laneMask, o_sameWord cleared to 0.
REQ-031 Reset mid-operation discards all in-flight requests; first request after deassertion accepted on first cycle with i_rst low.

Configuration
REQ-032 Macro TEX_ADDR_WINDOW_EN defined: window mask/offset applied per REQ-021.
REQ-033 TEX_ADDR_WINDOW_EN undefined: U''=U', V''=V'; window inputs ignored; flip, addressing, latency unchanged.

Verification
REQ-034 LANES=2, fmt=2, PageX=15, PageY=1, U0=255, V0=0x10, no flip/window -> o_texelAddr lane0 = {1,0x10,10'd191} (wrap), 2 cycles after acceptance.
REQ-035 fmt=0, PageX=2, U=0x37, XFlip=1 -> U'=0xC8, adr=128+50=178, subSel=0.
REQ-036 Window MaskX=0x1F, OffsetX=0x05, U=0xFF (macro on) -> U''=0x2F; macro off -> U''=0xFF.
REQ-037 Stream 8 requests, i_ready toggling 1,0,0,1,... -> outputs in order, none lost/duplicated, o_ready low only with both stages full and i_ready low.
REQ-038 fmt=1, lane0 U=0x40, lane1 U=0x41, same V, mask 2'b11 -> o_sameWord=2'b11, subSel lane0=0, lane1=1.
REQ-039 Assert i_rst with both stages full -> o_valid=0 next cycle; post-reset request produces output 2 cycles later with correct data.
